// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives a length header and an MSB-first payload after a flag strobe.
module serial_frame_rx #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serIn,
    input  logic              seqValid,
    output logic [DATA_W-1:0] dataOut,
    output logic [LEN_W-1:0]  lenOut,
    output logic              outValid,
    output logic              err,
    output logic              busy
);
    localparam int CW = $clog2((LEN_W > DATA_W ? LEN_W : DATA_W) + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] PAY  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    logic [2:0]        state, state_nx, hdr_dec;
    logic [LEN_W-1:0]  hdr, hdr_in;
    logic [DATA_W-1:0] pay, pay_sh;
    logic [CW-1:0]     cnt;
    logic              hdr_last, pay_last, hdr_big, frame_start;

    // In IDLE the first header bit is loaded fresh; in HDR it is shifted in, so the
    // completed header value is available in the cycle of its last bit.
    always_comb begin
        hdr_in      = (state == IDLE) ? LEN_W'(serIn) : ((hdr << 1) | LEN_W'(serIn));
        pay_sh      = (pay << 1) | DATA_W'(serIn);
        frame_start = (state == IDLE) && seqValid;
        hdr_last    = (state == IDLE) ? (LEN_W == 1) : (cnt == CW'(LEN_W - 1));
        pay_last    = (cnt + CW'(1)) == CW'(hdr);
        hdr_big     = 32'(hdr_in) > 32'(DATA_W);
        hdr_dec     = (hdr_in == '0) ? DONE : (hdr_big ? ERR : PAY);
    end

    // Next-state decision; the header decision is shared by IDLE (LEN_W=1) and HDR.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = seqValid ? (hdr_last ? hdr_dec : HDR) : IDLE;
            HDR:     state_nx = hdr_last ? hdr_dec : HDR;
            PAY:     state_nx = pay_last ? DONE : PAY;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and state registers; results latch only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hdr     <= '0;
            pay     <= '0;
            cnt     <= '0;
            dataOut <= '0;
            lenOut  <= '0;
        end else begin
            state <= state_nx;
            if (frame_start || state == HDR)
                hdr <= hdr_in;
            if (frame_start)
                pay <= '0;
            else if (state == PAY)
                pay <= pay_sh;
            if (frame_start || state == HDR || state == PAY)
                cnt <= (state != PAY && state_nx == PAY) ? '0 : cnt + CW'(1);
            else
                cnt <= '0;
            if (state_nx == DONE) begin
                dataOut <= (state == PAY) ? pay_sh : '0;
                lenOut  <= (state == PAY) ? hdr : '0;
            end
        end
    end

    assign outValid = (state == DONE);
    assign err      = (state == ERR);
    assign busy     = (state != IDLE);
endmodule
